// File: rtl/sgpr_rd_port_arbiter_pkg.sv
// Shared constants for the SGPR read-port arbiter slice.
// Purpose : default geometry of the SGPR read port and the
//           round-robin pointer helper used by the arbiter top.
// Ports   : none (package).
package sgpr_rd_port_arbiter_pkg;

  localparam int SGPR_NUM_PORTS  = 8;
  localparam int SGPR_ADDR_W     = 9;
  localparam int SGPR_DATA_W     = 32;
  localparam int SGPR_RD_LATENCY = 1;
  localparam int RR_PTR_W        = 3;

  // Next round-robin start position: one past the winner, wrapping 7 -> 0.
  function automatic logic [RR_PTR_W-1:0] ptr_inc(input logic [RR_PTR_W-1:0] w);
    return w + RR_PTR_W'(1);
  endfunction

endpackage

// File: rtl/sgpr_rd_port_arbiter_rr_arbiter_8.sv
// Purely combinational 8-way round-robin picker.
// Purpose : choose the first set request bit scanning upward from ptr,
//           wrapping 7 -> 0; nothing is granted when en is low.
// Ports   : req[7:0]    request vector
//           ptr[2:0]    scan start position
//           en          grant enable (low blocks every grant)
//           gnt[7:0]    one-hot grant, zero when nothing wins
//           winner[2:0] index of the granted bit (0 when no grant)
module rr_arbiter_8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  input  logic       en,
  output logic [7:0] gnt,
  output logic [2:0] winner
);

  logic       found;
  logic [2:0] idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < 8; k++) begin
      // 3-bit addition gives the 7 -> 0 wrap for free.
      idx = ptr + 3'(k);
      if (en && !found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        winner      = idx;
      end
    end
  end

endmodule

// File: rtl/sgpr_rd_port_arbiter.sv
// Round-robin arbiter sharing the single SGPR read port among 8 requesters.
// Purpose : grant at most one read per cycle, drive the SGPR read port in
//           the grant cycle, and route the returning data back to its owner
//           RD_LATENCY cycles later through a never-stalling tag pipeline.
// Ports   : clk, rst_n          clock, async active-low reset
//           req                per-requester level request
//           req_addr           requester i address at [i*ADDR_W +: ADDR_W]
//           hold               blocks all grants this cycle
//           gnt                one-hot grant (combinational)
//           rd_data_valid      one-hot owner of port_rd_data
//           port_rd_data       returned data, shared by all requesters
//           rd_en, rd_addr     SGPR read port request side
//           rd_data            SGPR read data, valid RD_LATENCY after rd_en
module sgpr_rd_port_arbiter
  import sgpr_rd_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = SGPR_NUM_PORTS,
  parameter int ADDR_W     = SGPR_ADDR_W,
  parameter int DATA_W     = SGPR_DATA_W,
  parameter int RD_LATENCY = SGPR_RD_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic                        hold,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rd_data_valid,
  output logic [DATA_W-1:0]           port_rd_data,
  output logic                        rd_en,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic [DATA_W-1:0]           rd_data
);

  logic [RR_PTR_W-1:0]  rr_ptr_q;
  logic [RR_PTR_W-1:0]  rr_ptr_d;
  logic [RR_PTR_W-1:0]  winner;
  logic [NUM_PORTS-1:0] arb_gnt;
  logic                 arb_en;

  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [NUM_PORTS-1:0]  tag_own_q [RD_LATENCY];

  // Folding rst_n into the enable forces gnt/rd_en/rd_addr to 0 in reset.
  assign arb_en = rst_n & ~hold;

  rr_arbiter_8 u_rr_arbiter_8 (
    .req    (req),
    .ptr    (rr_ptr_q),
    .en     (arb_en),
    .gnt    (arb_gnt),
    .winner (winner)
  );

  assign gnt   = arb_gnt;
  assign rd_en = |arb_gnt;

  // AND-OR address mux: zero when nothing is granted, never X.
  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_gnt[i]) begin
        rd_addr = rd_addr | req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (rd_en) begin
      rr_ptr_d = ptr_inc(winner);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Stage 0 captures the grant issued this cycle; each later stage is one
  // cycle older. The last stage lines up with rd_data from the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_own_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= rd_en;
      tag_own_q[0] <= arb_gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
    end
  end

  assign rd_data_valid = tag_vld_q[RD_LATENCY-1] ? tag_own_q[RD_LATENCY-1] : '0;
  assign port_rd_data  = rd_data;

endmodule

// File: tb/tb_sgpr_rd_port_arbiter.sv
// Bench for sgpr_rd_port_arbiter: three instances (RD_LATENCY 1, 2, 3) share
// one stimulus stream; a behavioural model predicts grants and returns.
module tb_sgpr_rd_port_arbiter;

  localparam int NP = 8;
  localparam int AW = 9;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    req = '0;
  logic             hold = 1'b0;
  logic [DW-1:0]    rd_data = '0;
  logic [AW-1:0]    addr_tb [NP];
  logic [NP*AW-1:0] req_addr;

  logic [NP-1:0] gnt_o   [1:3];
  logic [NP-1:0] vld_o   [1:3];
  logic [DW-1:0] pdata_o [1:3];
  logic          rden_o  [1:3];
  logic [AW-1:0] raddr_o [1:3];

  int checks = 0;
  int errors = 0;

  // Model state: round-robin pointer and history of past grants
  // (hist[0] = grant of the previous cycle, hist[1] = two cycles ago, ...).
  int            mptr = 0;
  logic [NP-1:0] hist [3];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NP; i++) req_addr[i*AW +: AW] = addr_tb[i];
  end

  sgpr_rd_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .hold(hold),
    .gnt(gnt_o[1]), .rd_data_valid(vld_o[1]), .port_rd_data(pdata_o[1]),
    .rd_en(rden_o[1]), .rd_addr(raddr_o[1]), .rd_data(rd_data));

  sgpr_rd_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .hold(hold),
    .gnt(gnt_o[2]), .rd_data_valid(vld_o[2]), .port_rd_data(pdata_o[2]),
    .rd_en(rden_o[2]), .rd_addr(raddr_o[2]), .rd_data(rd_data));

  sgpr_rd_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .hold(hold),
    .gnt(gnt_o[3]), .rd_data_valid(vld_o[3]), .port_rd_data(pdata_o[3]),
    .rd_en(rden_o[3]), .rd_addr(raddr_o[3]), .rd_data(rd_data));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner = first requesting port met while walking from ptr upward mod 8.
  function automatic int model_winner(input logic [NP-1:0] r, input logic h,
                                      input logic rn, input int ptr);
    if (!rn || h) return -1;
    for (int k = 0; k < NP; k++) begin
      if (r[(ptr + k) % NP]) return (ptr + k) % NP;
    end
    return -1;
  endfunction

  // Compare process: every cycle, all three instances against the model.
  always @(negedge clk) begin
    int            w;
    logic [NP-1:0] eg;
    logic [AW-1:0] ea;
    logic [NP-1:0] ev;
    w  = model_winner(req, hold, rst_n, mptr);
    eg = '0;
    ea = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ea    = addr_tb[w];
    end
    for (int L = 1; L <= 3; L++) begin
      ev = rst_n ? hist[L-1] : '0;
      chk($sformatf("gnt_L%0d", L), 32'(gnt_o[L]), 32'(eg));
      chk($sformatf("rd_en_L%0d", L), 32'(rden_o[L]), 32'(w >= 0));
      chk($sformatf("rd_addr_L%0d", L), 32'(raddr_o[L]), 32'(ea));
      chk($sformatf("valid_L%0d", L), 32'(vld_o[L]), 32'(ev));
      chk($sformatf("pdata_L%0d", L), pdata_o[L], rd_data);
    end
  end

  // Model state advance on the active edge (inputs change only #1 later).
  always @(posedge clk) begin
    int w;
    if (!rst_n) begin
      mptr = 0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
    end else begin
      w = model_winner(req, hold, rst_n, mptr);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (w >= 0) ? NP'(1 << w) : '0;
      if (w >= 0) mptr = (w + 1) % NP;
    end
  end

  task automatic apply(input logic [NP-1:0] r, input logic h);
    @(posedge clk);
    #1;
    req     = r;
    hold    = h;
    rd_data = $urandom;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NP; i++) addr_tb[i] = AW'(9'h040 * i + 9'h00F);
    for (int i = 0; i < 3; i++) hist[i] = '0;

    // Reset: everything quiet even with all requesting.
    apply(8'hFF, 1'b0);
    chk("rst_gnt", 32'(gnt_o[1]), 32'h0);
    chk("rst_rd_en", 32'(rden_o[2]), 32'h0);
    chk("rst_rd_addr", 32'(raddr_o[3]), 32'h0);
    chk("rst_valid", 32'(vld_o[3]), 32'h0);
    apply(8'h00, 1'b0);
    rst_n = 1'b1;

    // All eight requesting from reset: 0,1,...,7,0.
    for (int k = 0; k < 9; k++) begin
      apply(8'hFF, 1'b0);
      chk("all8_gnt", 32'(gnt_o[1]), 32'(1 << (k % 8)));
      chk("all8_addr", 32'(raddr_o[2]), 32'(addr_tb[k % 8]));
    end
    repeat (3) apply(8'h00, 1'b0);

    // Single requester, port 3.
    addr_tb[3] = 9'h05F;
    apply(8'h08, 1'b0);
    chk("single_gnt", 32'(gnt_o[1]), 32'h08);
    chk("single_rd_en", 32'(rden_o[1]), 32'h1);
    chk("single_rd_addr", 32'(raddr_o[1]), 32'h05F);
    apply(8'h00, 1'b0);
    chk("single_valid", 32'(vld_o[1]), 32'h08);
    chk("single_pdata", pdata_o[1], rd_data);
    chk("model_ptr", 32'(mptr), 32'd4);
    apply(8'hFF, 1'b0);
    chk("after_single_gnt", 32'(gnt_o[2]), 32'h10);

    // Hold for three cycles with everyone requesting.
    for (int k = 0; k < 3; k++) begin
      apply(8'hFF, 1'b1);
      chk("hold_gnt", 32'(gnt_o[1]), 32'h0);
      chk("hold_rd_en", 32'(rden_o[1]), 32'h0);
      chk("hold_rd_addr", 32'(raddr_o[1]), 32'h0);
    end
    apply(8'hFF, 1'b0);
    chk("post_hold_gnt", 32'(gnt_o[3]), 32'h20);
    repeat (3) apply(8'h00, 1'b0);

    // Back-to-back grants 2,5,2 and their returns on the latency-3 instance.
    apply(8'h04, 1'b0);
    apply(8'h20, 1'b0);
    apply(8'h04, 1'b0);
    apply(8'h00, 1'b0);
    chk("lat3_ret0", 32'(vld_o[3]), 32'h04);
    apply(8'h00, 1'b0);
    chk("lat3_ret1", 32'(vld_o[3]), 32'h20);
    apply(8'h00, 1'b0);
    chk("lat3_ret2", 32'(vld_o[3]), 32'h04);

    // Wrap: grant 6 puts the pointer at 7, then only port 0 requests.
    apply(8'h40, 1'b0);
    chk("wrap_pre_gnt", 32'(gnt_o[1]), 32'h40);
    apply(8'h01, 1'b0);
    chk("wrap_gnt", 32'(gnt_o[1]), 32'h01);
    apply(8'h03, 1'b0);
    chk("wrap_next_gnt", 32'(gnt_o[1]), 32'h02);

    // Withdrawn request under hold leaves no trace.
    apply(8'h10, 1'b1);
    apply(8'h00, 1'b0);
    repeat (3) apply(8'h00, 1'b0);

    // Reset one cycle after a grant.
    apply(8'h01, 1'b0);
    chk("prerst_gnt", 32'(gnt_o[2]), 32'h01);
    @(posedge clk);
    #1;
    req   = 8'hFF;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_gnt", 32'(gnt_o[2]), 32'h0);
    chk("midrst_valid1", 32'(vld_o[1]), 32'h0);
    chk("midrst_valid2", 32'(vld_o[2]), 32'h0);
    apply(8'h00, 1'b0);
    rst_n = 1'b1;
    apply(8'h00, 1'b0);
    chk("postrst_valid3", 32'(vld_o[3]), 32'h0);
    apply(8'h0C, 1'b0);
    chk("postrst_gnt", 32'(gnt_o[1]), 32'h04);
    repeat (4) apply(8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
